video_stream_gen: RTL and testbench
===================================

# video_stream_gen

Synthetic video source for the convolution pipeline. It produces the same stream the camera path delivers to the filter kernels: active-low vertical sync, horizontal sync and blank, plus RGB pixels, one pixel per clock. It sits in front of a kernel in place of the D8M/line-buffer feed, so filters can be exercised on the board and in simulation with known, repeatable images.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `PIXEL_DEPTH`, 8: bits per colour channel.

Ports:
- `clk`  in  1  pixel clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `start_i`  in  1  level; high requests streaming, low requests a stop at the end of the current frame.
- `pattern_i`  in  2  pattern select; latched only at frame start.
- `vs_no`  out  1  vertical sync, active low.
- `hs_no`  out  1  horizontal sync, active low.
- `blank_no`  out  1  low outside the active region.
- `en_o`  out  1  stream-valid enable; drives the downstream kernel `en_i`.
- `output_R`, `output_G`, `output_B`  out  `PIXEL_DEPTH` each  pixel value; 0 whenever blanking.
- `frame_done_o`  out  1  one-cycle pulse on the last pixel of each frame.

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- States:
  - IDLE -> RUN when `start_i`=1.
  - RUN -> STOPPING when `start_i`=0 mid-frame.
  - STOPPING -> IDLE on the last pixel of the frame.
  - STOPPING -> RUN when `start_i` returns to 1 before the frame ends. No frame gap; the frame continues.
- Counters:
  - `h_cnt` runs 0..H_TOTAL-1 and wraps to 0.
  - `v_cnt` increments on the `h_cnt` wrap and wraps 0..V_TOTAL-1.
  - Both are held at 0 in IDLE.
- Active region: `h_cnt`<H_ACTIVE and `v_cnt`<V_ACTIVE.
- `hs_no`=0 when H_ACTIVE+H_FP ≤ `h_cnt` < H_ACTIVE+H_FP+H_SYNC.
- `vs_no`=0 over the analogous `v_cnt` range.
- The pattern register loads `pattern_i` when `h_cnt`=`v_cnt`=0 in RUN, and on the IDLE->RUN transition.
- Patterns (x=`h_cnt`, y=`v_cnt`, all channels 8-bit at the default depth):
  - 0: solid grey, R=G=B=0x80.
  - 1: eight vertical colour bars, H_ACTIVE/8 wide each: white, yellow, cyan, green, magenta, red, blue, black. Full-scale components are 0xFF.
  - 2: horizontal ramp, R=G=B=x[PIXEL_DEPTH+1:2].
  - 3: 32×32 checkerboard; white when x[5]^y[5] is 1, else black.
- `en_o`=1 on every cycle in RUN or STOPPING, including blanking intervals, so the downstream window shifts continuously. `en_o`=0 in IDLE.
- In IDLE: `vs_no`=`hs_no`=1, `blank_no`=0, RGB=0.
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE; counters go to 0.
  - Pattern register goes to 0.
  - Outputs take their IDLE values; `frame_done_o`=0.

## Timing
- All outputs are registered.
- Output at cycle t reflects the counter values at cycle t-1 (1-cycle latency). Sync, blank, RGB and `en_o` stay mutually aligned.
- `start_i` is sampled high in IDLE at edge 0. Counters are (0,0) after edge 1. Pixel (0,0) appears on the outputs after edge 2.
- `frame_done_o` is high for exactly the one output cycle carrying pixel (H_TOTAL-1, V_TOTAL-1).
- Frame period is H_TOTAL×V_TOTAL = 420000 clocks.
- A `pattern_i` change mid-frame has no effect until the next frame start.

## Configuration
- `STREAM_GEN_MOVING_BAR_EN` defined:
  - Adds a frame counter and a 16-pixel-wide white vertical bar overlaid on every pattern.
  - The bar's left edge is (4×frame_count) mod H_ACTIVE, and advances at each `frame_done_o`.
  - If the bar would cross x=H_ACTIVE, it is clipped at H_ACTIVE; it does not wrap within the line.
  - The frame counter resets to 0 on reset and when entering IDLE.
- Not defined: no overlay and no frame counter logic; output is the pure pattern.

## Test plan
- Reset behaviour: assert `rst_ni`=0 mid-line, then release with `start_i`=0 -> `vs_no`=`hs_no`=1, `blank_no`=0, RGB=0, `en_o`=0, held indefinitely.
- Sync timing: `start_i`=1, pattern 0 -> `hs_no` low for 96 clocks starting 656 clocks after line start. `vs_no` low for 2 lines starting at line 490. `blank_no` high for 640×480 pixels per frame. All active pixels = 0x80.
- Colour bars: pattern 1 -> pixel x=0 is FFFFFF, x=80 is FFFF00, x=560 is 000000, x=639 is 000000.
- Pattern latching: switch `pattern_i` from 2 to 3 at line 100 -> current frame stays a ramp (x=400 gives 0x64). The next frame is a checkerboard: (32,0) is white, (32,32) is black.
- Stop and frame pulse: drop `start_i` at line 200 -> frame completes. `frame_done_o` pulses once, then state is IDLE and `en_o`=0. Re-asserting `start_i` before the last pixel keeps streaming with no gap.
- With `STREAM_GEN_MOVING_BAR_EN`: frame 0 bar covers x=0..15; frame 3 bar covers x=12..27, white over the current pattern.

Source files
------------

// File: rtl/video_stream_gen.sv
// video_stream_gen
//   Synthetic video source for the convolution pipeline. Emits the same
//   stream the camera path delivers to the filter kernels: active-low
//   vsync/hsync/blank plus RGB, one pixel per clock, with selectable
//   test patterns (grey, colour bars, horizontal ramp, checkerboard).
//
// Ports
//   clk           pixel clock
//   rst_ni        asynchronous active-low reset
//   start_i       level: high streams, low stops at the end of the frame
//   pattern_i     pattern select, latched at frame start
//   vs_no, hs_no  vertical / horizontal sync, active low
//   blank_no      low outside the active region
//   en_o          stream-valid enable for the downstream kernel
//   output_R/G/B  pixel value, 0 while blanking
//   frame_done_o  one-cycle pulse on the last pixel of each frame
//
// Optional feature macro: STREAM_GEN_MOVING_BAR_EN
//   When defined, a 16-pixel white vertical bar is overlaid on every
//   pattern; its left edge advances by 4 pixels per frame (mod H_ACTIVE).
module video_stream_gen #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned PIXEL_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [1:0]             pattern_i,
    output logic                   vs_no,
    output logic                   hs_no,
    output logic                   blank_no,
    output logic                   en_o,
    output logic [PIXEL_DEPTH-1:0] output_R,
    output logic [PIXEL_DEPTH-1:0] output_G,
    output logic [PIXEL_DEPTH-1:0] output_B,
    output logic                   frame_done_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    // Coordinate widths wide enough for the ramp slice and checker bit 5.
    localparam int unsigned XW0     = (HW > PIXEL_DEPTH + 2) ? HW : PIXEL_DEPTH + 2;
    localparam int unsigned XW      = (XW0 > 6) ? XW0 : 6;
    localparam int unsigned YW      = (VW > 6) ? VW : 6;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [PIXEL_DEPTH-1:0] GREY = {1'b1, {(PIXEL_DEPTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOPPING
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_cnt_run;
    logic [HW-1:0]          r_h_cnt;
    logic [VW-1:0]          r_v_cnt;
    logic [1:0]             r_pattern;
    logic                   r_vs_n, r_hs_n, r_blank_n, r_en, r_fd;
    logic [PIXEL_DEPTH-1:0] r_R, r_G, r_B;

    logic [XW-1:0]          w_x;
    logic [YW-1:0]          w_y;
    logic                   w_last;
    logic                   w_frame_start;
    logic                   w_active;
    logic                   w_hs_n, w_vs_n;
    logic [1:0]             w_pat;
    logic [2:0]             w_bar_idx;
    logic [PIXEL_DEPTH-1:0] w_r, w_g, w_b;

    assign w_x           = XW'(r_h_cnt);
    assign w_y           = YW'(r_v_cnt);
    assign w_last        = r_cnt_run && (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);
    assign w_frame_start = r_cnt_run && (r_state == S_RUN) && (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_active      = (w_x < XW'(H_ACTIVE)) && (w_y < YW'(V_ACTIVE));
    assign w_hs_n        = !((w_x >= XW'(H_ACTIVE + H_FP)) && (w_x < XW'(H_ACTIVE + H_FP + H_SYNC)));
    assign w_vs_n        = !((w_y >= YW'(V_ACTIVE + V_FP)) && (w_y < YW'(V_ACTIVE + V_FP + V_SYNC)));
    // The register loads at the frame-start pixel; bypass it so that pixel
    // already uses the newly selected pattern.
    assign w_pat         = w_frame_start ? pattern_i : r_pattern;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (start_i) w_state_nxt = S_RUN;
            S_RUN:      if (!start_i) w_state_nxt = w_last ? S_IDLE : S_STOPPING;
            S_STOPPING: begin
                if (start_i)     w_state_nxt = S_RUN;
                else if (w_last) w_state_nxt = S_IDLE;
            end
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // r_cnt_run lags the IDLE->RUN transition by one cycle, so counters read
    // (0,0) after the second edge and pixel (0,0) leaves on the third.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_cnt_run <= 1'b0;
            r_pattern <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt_run <= (r_state != S_IDLE) && (w_state_nxt != S_IDLE);
            if ((r_state == S_IDLE && start_i) ||
                (r_state == S_RUN && r_h_cnt == '0 && r_v_cnt == '0))
                r_pattern <= pattern_i;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!r_cnt_run) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

`ifdef STREAM_GEN_MOVING_BAR_EN
    // Frame counter kept pre-scaled as the bar's left edge: 4*frames mod H_ACTIVE.
    logic [XW-1:0] r_bar_x;
    logic [XW-1:0] w_bar_step;
    assign w_bar_step = r_bar_x + XW'(4);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni)
            r_bar_x <= '0;
        else if (r_state == S_IDLE)
            r_bar_x <= '0;
        else if (w_last)
            r_bar_x <= (w_bar_step >= XW'(H_ACTIVE)) ? w_bar_step - XW'(H_ACTIVE) : w_bar_step;
    end
`endif

    always_comb begin
        w_r       = '0;
        w_g       = '0;
        w_b       = '0;
        w_bar_idx = '0;
        for (int unsigned k = 1; k < 8; k++)
            if (w_x >= XW'(k * BAR_W)) w_bar_idx = 3'(k);
        case (w_pat)
            2'd0: begin
                w_r = GREY;
                w_g = GREY;
                w_b = GREY;
            end
            // Bar order white..black maps to the inverted index bits.
            2'd1: begin
                w_r = {PIXEL_DEPTH{~w_bar_idx[1]}};
                w_g = {PIXEL_DEPTH{~w_bar_idx[2]}};
                w_b = {PIXEL_DEPTH{~w_bar_idx[0]}};
            end
            2'd2: begin
                w_r = w_x[PIXEL_DEPTH+1:2];
                w_g = w_x[PIXEL_DEPTH+1:2];
                w_b = w_x[PIXEL_DEPTH+1:2];
            end
            default: begin
                w_r = {PIXEL_DEPTH{w_x[5] ^ w_y[5]}};
                w_g = {PIXEL_DEPTH{w_x[5] ^ w_y[5]}};
                w_b = {PIXEL_DEPTH{w_x[5] ^ w_y[5]}};
            end
        endcase
`ifdef STREAM_GEN_MOVING_BAR_EN
        // Clipping at H_ACTIVE falls out of the active-region gating below.
        if (w_x >= r_bar_x && w_x < r_bar_x + XW'(16)) begin
            w_r = '1;
            w_g = '1;
            w_b = '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vs_n    <= 1'b1;
            r_hs_n    <= 1'b1;
            r_blank_n <= 1'b0;
            r_en      <= 1'b0;
            r_fd      <= 1'b0;
            r_R       <= '0;
            r_G       <= '0;
            r_B       <= '0;
        end else if (!r_cnt_run) begin
            r_vs_n    <= 1'b1;
            r_hs_n    <= 1'b1;
            r_blank_n <= 1'b0;
            r_en      <= 1'b0;
            r_fd      <= 1'b0;
            r_R       <= '0;
            r_G       <= '0;
            r_B       <= '0;
        end else begin
            r_vs_n    <= w_vs_n;
            r_hs_n    <= w_hs_n;
            r_blank_n <= w_active;
            r_en      <= 1'b1;
            r_fd      <= w_last;
            r_R       <= w_active ? w_r : '0;
            r_G       <= w_active ? w_g : '0;
            r_B       <= w_active ? w_b : '0;
        end
    end

    assign vs_no        = r_vs_n;
    assign hs_no        = r_hs_n;
    assign blank_no     = r_blank_n;
    assign en_o         = r_en;
    assign frame_done_o = r_fd;
    assign output_R     = r_R;
    assign output_G     = r_G;
    assign output_B     = r_B;

endmodule

// File: tb/tb_video_stream_gen.sv
// tb_video_stream_gen
//   Directed bench for video_stream_gen using a reduced 80x46 raster
//   (64x40 active) so several whole frames fit in a short run. Pixel
//   positions are tracked from the cycle start_i is first sampled: the
//   output after edge t0+2+k carries raster pixel k.
module tb_video_stream_gen;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 40, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
`ifdef STREAM_GEN_MOVING_BAR_EN
    localparam bit BAR_EN = 1'b1;
`else
    localparam bit BAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic [1:0] pattern_i = 2'd0;
    logic       vs_no, hs_no, blank_no, en_o, frame_done_o;
    logic [7:0] output_R, output_G, output_B;

    video_stream_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIXEL_DEPTH(8)
    ) dut (
        .clk(clk), .rst_ni(rst_ni), .start_i(start_i), .pattern_i(pattern_i),
        .vs_no(vs_no), .hs_no(hs_no), .blank_no(blank_no), .en_o(en_o),
        .output_R(output_R), .output_G(output_G), .output_B(output_B),
        .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    int t0 = 0;

    typedef struct {
        int          f, x, y;
        logic [23:0] rgb;
        logic        hs, vs, bl, fd;
        int          set_pat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int f, input int x, input int y, input logic [23:0] rgb,
                                input logic hs, input logic vs, input logic bl, input logic fd,
                                input int set_pat);
        vec_t v;
        v.f = f; v.x = x; v.y = y; v.rgb = rgb;
        v.hs = hs; v.vs = vs; v.bl = bl; v.fd = fd; v.set_pat = set_pat;
        return v;
    endfunction

    function automatic bit in_bar(input int f, input int x, input int y);
        int l;
        l = (4 * f) % HA;
        return BAR_EN && x < HA && y < VA && x >= l && x < l + 16;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string name);
        chk(name, {3'b0, vs_no, hs_no, blank_no, en_o, frame_done_o, output_R, output_G, output_B},
            {3'b0, 5'b11000, 24'h0});
    endtask

    task automatic wait_idx(input int k);
        int e;
        e = t0 + 2 + k;
        if (cyc > e) chk("schedule_late", cyc, e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic start_stream(input logic [1:0] p);
        @(negedge clk);
        pattern_i = p;
        start_i   = 1'b1;
        t0        = cyc + 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int bad, fd, last;
        int nbl, nhs, nvs, nfd, nen0, nbad, nbpos, hs_first, vs_first;
        logic [23:0] exp_px;
        vec_t v;

        // frame, x, y, rgb, hs, vs, blank, frame_done, pattern to drive afterwards
        vecs.push_back(mk(0,  0,  0, 24'h808080, 1, 1, 1, 0, -1));
        vecs.push_back(mk(0, 63,  0, 24'h808080, 1, 1, 1, 0, -1));
        vecs.push_back(mk(0, 64,  0, 24'h000000, 1, 1, 0, 0, -1));
        vecs.push_back(mk(0, 67,  0, 24'h000000, 1, 1, 0, 0, -1));
        vecs.push_back(mk(0, 68,  0, 24'h000000, 0, 1, 0, 0, -1));
        vecs.push_back(mk(0, 75,  0, 24'h000000, 0, 1, 0, 0, -1));
        vecs.push_back(mk(0, 76,  0, 24'h000000, 1, 1, 0, 0, -1));
        vecs.push_back(mk(0, 40, 39, 24'h808080, 1, 1, 1, 0, -1));
        vecs.push_back(mk(0,  0, 40, 24'h000000, 1, 1, 0, 0, -1));
        vecs.push_back(mk(0,  0, 41, 24'h000000, 1, 1, 0, 0, -1));
        vecs.push_back(mk(0,  0, 42, 24'h000000, 1, 0, 0, 0, -1));
        vecs.push_back(mk(0, 70, 43, 24'h000000, 0, 0, 0, 0, -1));
        vecs.push_back(mk(0,  0, 44, 24'h000000, 1, 1, 0, 0,  1));
        vecs.push_back(mk(0, 78, 45, 24'h000000, 1, 1, 0, 0, -1));
        vecs.push_back(mk(0, 79, 45, 24'h000000, 1, 1, 0, 1, -1));
        vecs.push_back(mk(1,  0,  0, 24'hFFFFFF, 1, 1, 1, 0, -1));
        vecs.push_back(mk(1,  8,  3, 24'hFFFF00, 1, 1, 1, 0, -1));
        vecs.push_back(mk(1, 16,  3, 24'h00FFFF, 1, 1, 1, 0, -1));
        vecs.push_back(mk(1, 24,  3, 24'h00FF00, 1, 1, 1, 0, -1));
        vecs.push_back(mk(1, 39,  3, 24'hFF00FF, 1, 1, 1, 0, -1));
        vecs.push_back(mk(1, 40,  3, 24'hFF0000, 1, 1, 1, 0, -1));
        vecs.push_back(mk(1, 48,  3, 24'h0000FF, 1, 1, 1, 0, -1));
        vecs.push_back(mk(1, 56,  3, 24'h000000, 1, 1, 1, 0, -1));
        vecs.push_back(mk(1, 63,  3, 24'h000000, 1, 1, 1, 0,  2));
        vecs.push_back(mk(2,  0,  0, 24'h000000, 1, 1, 1, 0, -1));
        vecs.push_back(mk(2, 40,  5, 24'h0A0A0A, 1, 1, 1, 0, -1));
        vecs.push_back(mk(2, 63,  5, 24'h0F0F0F, 1, 1, 1, 0, -1));
        vecs.push_back(mk(2,  5, 20, 24'h010101, 1, 1, 1, 0,  3));
        vecs.push_back(mk(2, 40, 21, 24'h0A0A0A, 1, 1, 1, 0, -1));
        vecs.push_back(mk(2, 40, 39, 24'h0A0A0A, 1, 1, 1, 0, -1));
        vecs.push_back(mk(3,  0,  0, 24'h000000, 1, 1, 1, 0, -1));
        vecs.push_back(mk(3, 32,  0, 24'hFFFFFF, 1, 1, 1, 0, -1));
        vecs.push_back(mk(3, 11,  5, 24'h000000, 1, 1, 1, 0, -1));
        vecs.push_back(mk(3, 12,  5, 24'h000000, 1, 1, 1, 0, -1));
        vecs.push_back(mk(3, 27,  5, 24'h000000, 1, 1, 1, 0, -1));
        vecs.push_back(mk(3, 28,  5, 24'h000000, 1, 1, 1, 0, -1));
        vecs.push_back(mk(3, 31, 31, 24'h000000, 1, 1, 1, 0,  0));
        vecs.push_back(mk(3,  0, 32, 24'hFFFFFF, 1, 1, 1, 0, -1));
        vecs.push_back(mk(3, 32, 32, 24'h000000, 1, 1, 1, 0, -1));
        vecs.push_back(mk(3, 63, 39, 24'h000000, 1, 1, 1, 0, -1));
        vecs.push_back(mk(4, 10, 10, 24'h808080, 1, 1, 1, 0, -1));

        // Reset and idle hold
        repeat (3) @(negedge clk);
        chk_idle("reset_held");
        rst_ni = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ({vs_no, hs_no, blank_no, en_o, frame_done_o, output_R, output_G, output_B} !== {5'b11000, 24'h0})
                bad++;
        end
        chk("idle_after_reset_bad_cycles", bad, 0);

        // Run 1: table vectors across five frames
        start_stream(2'd0);
        foreach (vecs[i]) begin
            v = vecs[i];
            wait_idx(v.f * FRAME + v.y * HT + v.x);
            exp_px = in_bar(v.f, v.x, v.y) ? 24'hFFFFFF : v.rgb;
            chk($sformatf("rgb_f%0d_x%0d_y%0d", v.f, v.x, v.y),
                {8'h0, output_R, output_G, output_B}, {8'h0, exp_px});
            chk($sformatf("ctl_f%0d_x%0d_y%0d", v.f, v.x, v.y),
                {27'h0, hs_no, vs_no, blank_no, en_o, frame_done_o}, {27'h0, v.hs, v.vs, v.bl, 1'b1, v.fd});
            if (v.set_pat >= 0) pattern_i = 2'(v.set_pat);
        end

        // Stop request mid-frame: frame completes, one done pulse, then idle
        wait_idx(4 * FRAME + 20 * HT);
        start_i = 1'b0;
        fd = 0;
        last = 5 * FRAME - 1;
        for (int k = 4 * FRAME + 20 * HT + 1; k <= last + 20; k++) begin
            wait_idx(k);
            if (frame_done_o) fd++;
            if (k == 4 * FRAME + 30 * HT) chk("stopping_en", en_o, 1);
            if (k == last) chk("stop_last_fd_en", {frame_done_o, en_o}, 2'b11);
            if (k == last + 1) chk_idle("stop_idle");
        end
        chk("stop_fd_count", fd, 1);
        repeat (100) @(negedge clk);
        chk_idle("stop_idle_held");

        // Run 2: full-frame scan with stop/resume inside the frame
        start_stream(2'd0);
        nbl = 0; nhs = 0; nvs = 0; nfd = 0; nen0 = 0; nbad = 0; nbpos = 0;
        hs_first = -1; vs_first = -1;
        for (int k = 0; k < FRAME; k++) begin
            int x, y;
            x = k % HT;
            y = k / HT;
            wait_idx(k);
            if (k == 10 * HT) start_i = 1'b0;
            if (k == 30 * HT) start_i = 1'b1;
            if (blank_no) nbl++;
            if (!hs_no) nhs++;
            if (!vs_no) nvs++;
            if (frame_done_o) nfd++;
            if (!en_o) nen0++;
            if (y == 0 && !hs_no && hs_first < 0) hs_first = x;
            if (x == 0 && !vs_no && vs_first < 0) vs_first = y;
            if (blank_no !== (x < HA && y < VA)) nbpos++;
            exp_px = in_bar(0, x, y) ? 24'hFFFFFF : 24'h808080;
            if (blank_no && {output_R, output_G, output_B} !== exp_px) nbad++;
            if (k == FRAME - 1) chk("scan_fd_last", frame_done_o, 1);
        end
        chk("scan_blank_high_count", nbl, HA * VA);
        chk("scan_hs_low_count", nhs, HS * VT);
        chk("scan_vs_low_count", nvs, VS * HT);
        chk("scan_fd_count", nfd, 1);
        chk("scan_en_gaps", nen0, 0);
        chk("scan_hs_first_x", hs_first, HA + HF);
        chk("scan_vs_first_line", vs_first, VA + VF);
        chk("scan_blank_position_errors", nbpos, 0);
        chk("scan_active_pixel_errors", nbad, 0);

        wait_idx(FRAME);
        chk("resume_next_frame", {7'h0, en_o, blank_no, output_R, output_G, output_B},
            {7'h0, 1'b1, 1'b1, 24'h808080});

        // Asynchronous reset mid-line, released with start low
        wait_idx(FRAME + 5 * HT + 30);
        #2 rst_ni = 1'b0;
        #1 chk_idle("async_reset_midline");
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset_held_midline");
        rst_ni = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ({vs_no, hs_no, blank_no, en_o, frame_done_o, output_R, output_G, output_B} !== {5'b11000, 24'h0})
                bad++;
        end
        chk("idle_after_midline_reset_bad_cycles", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
